vt52_cmd_engine: RTL and testbench

//  Parametrised VT52 command engine: consumes received bytes (valid/ready stream from the RX fifo) and

---
 rtl/vt52_cmd_engine.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_vt52_cmd_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vt52_cmd_engine.sv
// VT52 command engine: decodes received bytes into char-buffer writes, scroll base and cursor updates.
// Latency: one cycle from an accepted byte to its registered strobes; clear sweeps write one cell per cycle.
// Backpressure: ready is low for the whole clear sweep, so a held byte stays pending until the sweep ends.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   data/valid/ready           received byte stream (accepted when valid && ready)
//   new_first_char(_wen)       buffer address of screen row 0 (hardware scroll base) + strobe
//   new_char/_address/_wen     char-buffer write port
//   new_cursor_x/_y/_wen       cursor position + strobe
module vt52_cmd_engine #(
  parameter int ROWS      = 25,
  parameter int COLS      = 80,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11,
  parameter int TAB_WIDTH = 8,
  parameter int AUTOWRAP  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           data,
  input  logic                 valid,
  output logic                 ready,
  output logic [ADDR_BITS-1:0] new_first_char,
  output logic                 new_first_char_wen,
  output logic [7:0]           new_char,
  output logic [ADDR_BITS-1:0] new_char_address,
  output logic                 new_char_wen,
  output logic [COL_BITS-1:0]  new_cursor_x,
  output logic [ROW_BITS-1:0]  new_cursor_y,
  output logic                 new_cursor_wen
);

  localparam int AW1 = ADDR_BITS + 1;
  localparam int SIZE = ROWS * COLS;
  localparam logic [AW1-1:0]       SIZE_W    = AW1'(SIZE);
  localparam logic [AW1-1:0]       COLS_W    = AW1'(COLS);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SIZE - 1);
  localparam logic [ROW_BITS-1:0]  ROW_MAX   = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0]  COL_MAX   = COL_BITS'(COLS - 1);
  localparam logic [COL_BITS-1:0]  TAB_MASK  = COL_BITS'(TAB_WIDTH - 1);
  localparam logic [7:0]           ROW_MAX_B = 8'(ROWS - 1);
  localparam logic [7:0]           COL_MAX_B = 8'(COLS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ESC, S_YROW, S_YCOL, S_CLEAR} state_t;

  state_t               state_q, state_d;
  logic [COL_BITS-1:0]  cur_x_q, cur_x_d;
  logic [ROW_BITS-1:0]  cur_y_q, cur_y_d;
  logic [ADDR_BITS-1:0] first_char_q, first_char_d;
  logic [ROW_BITS-1:0]  yrow_q, yrow_d;
  logic [ADDR_BITS-1:0] clr_addr_q, clr_addr_d;
  logic [AW1-1:0]       clr_cnt_q, clr_cnt_d;
  logic [7:0]           new_char_q, new_char_d;
  logic [ADDR_BITS-1:0] new_char_address_q, new_char_address_d;
  logic                 new_char_wen_q, new_char_wen_d;
  logic                 new_cursor_wen_q, new_cursor_wen_d;
  logic                 new_first_char_wen_q, new_first_char_wen_d;

  logic                 accept;
  logic                 do_lf;
  logic [COL_BITS:0]    tab_x;

  // Sums stay below 2*SIZE, so one conditional subtract folds them into the ring.
  function automatic logic [ADDR_BITS-1:0] wrap_addr(input logic [AW1-1:0] sum);
    logic [AW1-1:0] s;
    s = sum;
    if (s >= SIZE_W) s = s - SIZE_W;
    return s[ADDR_BITS-1:0];
  endfunction

  function automatic logic [AW1-1:0] lin_off(input logic [ROW_BITS-1:0] r,
                                             input logic [COL_BITS-1:0] c);
    return AW1'(int'(r) * COLS) + AW1'(c);
  endfunction

  function automatic logic [ROW_BITS-1:0] row_of_byte(input logic [7:0] b);
    logic [7:0] v;
    v = b - 8'h20;
    if (b < 8'h20) return '0;
    if (v > ROW_MAX_B) return ROW_MAX;
    return ROW_BITS'(v);
  endfunction

  function automatic logic [COL_BITS-1:0] col_of_byte(input logic [7:0] b);
    logic [7:0] v;
    v = b - 8'h20;
    if (b < 8'h20) return '0;
    if (v > COL_MAX_B) return COL_MAX;
    return COL_BITS'(v);
  endfunction

  assign ready  = (state_q != S_CLEAR);
  assign accept = valid && ready;

  always_comb begin
    state_d              = state_q;
    cur_x_d              = cur_x_q;
    cur_y_d              = cur_y_q;
    first_char_d         = first_char_q;
    yrow_d               = yrow_q;
    clr_addr_d           = clr_addr_q;
    clr_cnt_d            = clr_cnt_q;
    new_char_d           = new_char_q;
    new_char_address_d   = new_char_address_q;
    new_char_wen_d       = 1'b0;
    new_cursor_wen_d     = 1'b0;
    new_first_char_wen_d = 1'b0;
    do_lf                = 1'b0;
    tab_x                = {1'b0, cur_x_q | TAB_MASK} + (COL_BITS+1)'(1);

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (data >= 8'h20 && data != 8'h7F) begin
            new_char_d         = data;
            new_char_address_d = wrap_addr({1'b0, first_char_q} + lin_off(cur_y_q, cur_x_q));
            new_char_wen_d     = 1'b1;
            new_cursor_wen_d   = 1'b1;
            if (cur_x_q != COL_MAX) begin
              cur_x_d = cur_x_q + COL_BITS'(1);
            end else if (AUTOWRAP != 0) begin
              cur_x_d = '0;
              do_lf   = 1'b1;
            end
          end else begin
            case (data)
              8'h0A: begin
                do_lf            = 1'b1;
                new_cursor_wen_d = 1'b1;
              end
              8'h0D: begin
                cur_x_d          = '0;
                new_cursor_wen_d = 1'b1;
              end
              8'h08: begin
                if (cur_x_q != '0) cur_x_d = cur_x_q - COL_BITS'(1);
                new_cursor_wen_d = 1'b1;
              end
              8'h09: begin
                cur_x_d          = (tab_x > {1'b0, COL_MAX}) ? COL_MAX : tab_x[COL_BITS-1:0];
                new_cursor_wen_d = 1'b1;
              end
              8'h1B:   state_d = S_ESC;
              default: ;
            endcase
          end
          // Line feed on the bottom row scrolls: the old top row becomes the new
          // bottom row, so its buffer address (the old first_char) is what gets blanked.
          if (do_lf) begin
            if (cur_y_q != ROW_MAX) begin
              cur_y_d = cur_y_q + ROW_BITS'(1);
            end else begin
              first_char_d         = wrap_addr({1'b0, first_char_q} + COLS_W);
              new_first_char_wen_d = 1'b1;
              clr_addr_d           = first_char_q;
              clr_cnt_d            = COLS_W;
              state_d              = S_CLEAR;
            end
          end
        end
      end

      S_ESC: begin
        if (accept) begin
          state_d = S_IDLE;
          case (data)
            8'h41: begin
              if (cur_y_q != '0) cur_y_d = cur_y_q - ROW_BITS'(1);
              new_cursor_wen_d = 1'b1;
            end
            8'h42: begin
              if (cur_y_q != ROW_MAX) cur_y_d = cur_y_q + ROW_BITS'(1);
              new_cursor_wen_d = 1'b1;
            end
            8'h43: begin
              if (cur_x_q != COL_MAX) cur_x_d = cur_x_q + COL_BITS'(1);
              new_cursor_wen_d = 1'b1;
            end
            8'h44: begin
              if (cur_x_q != '0) cur_x_d = cur_x_q - COL_BITS'(1);
              new_cursor_wen_d = 1'b1;
            end
            8'h48: begin
              cur_x_d          = '0;
              cur_y_d          = '0;
              new_cursor_wen_d = 1'b1;
            end
            8'h4A: begin
              clr_addr_d = wrap_addr({1'b0, first_char_q} + lin_off(cur_y_q, cur_x_q));
              clr_cnt_d  = SIZE_W - lin_off(cur_y_q, cur_x_q);
              state_d    = S_CLEAR;
            end
            8'h4B: begin
              clr_addr_d = wrap_addr({1'b0, first_char_q} + lin_off(cur_y_q, cur_x_q));
              clr_cnt_d  = COLS_W - AW1'(cur_x_q);
              state_d    = S_CLEAR;
            end
            8'h45: begin
              first_char_d         = '0;
              new_first_char_wen_d = 1'b1;
              cur_x_d              = '0;
              cur_y_d              = '0;
              new_cursor_wen_d     = 1'b1;
              clr_addr_d           = '0;
              clr_cnt_d            = SIZE_W;
              state_d              = S_CLEAR;
            end
            8'h59:   state_d = S_YROW;
            default: ;
          endcase
        end
      end

      S_YROW: begin
        if (accept) begin
          yrow_d  = row_of_byte(data);
          state_d = S_YCOL;
        end
      end

      S_YCOL: begin
        if (accept) begin
          cur_y_d          = yrow_q;
          cur_x_d          = col_of_byte(data);
          new_cursor_wen_d = 1'b1;
          state_d          = S_IDLE;
        end
      end

      S_CLEAR: begin
        // A count of zero costs one extra cycle so ready rises only after the
        // last write strobe has been presented.
        if (clr_cnt_q != '0) begin
          new_char_d         = 8'h20;
          new_char_address_d = clr_addr_q;
          new_char_wen_d     = 1'b1;
          clr_cnt_d          = clr_cnt_q - AW1'(1);
          clr_addr_d         = (clr_addr_q == LAST_ADDR) ? '0 : clr_addr_q + ADDR_BITS'(1);
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q              <= S_CLEAR;
      cur_x_q              <= '0;
      cur_y_q              <= '0;
      first_char_q         <= '0;
      yrow_q               <= '0;
      clr_addr_q           <= '0;
      clr_cnt_q            <= SIZE_W;
      new_char_q           <= 8'h20;
      new_char_address_q   <= '0;
      new_char_wen_q       <= 1'b0;
      new_cursor_wen_q     <= 1'b0;
      new_first_char_wen_q <= 1'b0;
    end else begin
      state_q              <= state_d;
      cur_x_q              <= cur_x_d;
      cur_y_q              <= cur_y_d;
      first_char_q         <= first_char_d;
      yrow_q               <= yrow_d;
      clr_addr_q           <= clr_addr_d;
      clr_cnt_q            <= clr_cnt_d;
      new_char_q           <= new_char_d;
      new_char_address_q   <= new_char_address_d;
      new_char_wen_q       <= new_char_wen_d;
      new_cursor_wen_q     <= new_cursor_wen_d;
      new_first_char_wen_q <= new_first_char_wen_d;
    end
  end

  assign new_first_char     = first_char_q;
  assign new_first_char_wen = new_first_char_wen_q;
  assign new_char           = new_char_q;
  assign new_char_address   = new_char_address_q;
  assign new_char_wen       = new_char_wen_q;
  assign new_cursor_x       = cur_x_q;
  assign new_cursor_y       = cur_y_q;
  assign new_cursor_wen     = new_cursor_wen_q;

endmodule

// File: tb/tb_vt52_cmd_engine.sv
// Bench for vt52_cmd_engine (80x25 defaults): table of single-byte vectors plus
// hand-written sequences for clear sweeps, scrolling, held bytes and reset mid-sweep.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_vt52_cmd_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data = 8'h00;
  logic        valid = 1'b0;
  logic        ready;
  logic [10:0] new_first_char;
  logic        new_first_char_wen;
  logic [7:0]  new_char;
  logic [10:0] new_char_address;
  logic        new_char_wen;
  logic [6:0]  new_cursor_x;
  logic [4:0]  new_cursor_y;
  logic        new_cursor_wen;

  int n_checks = 0;
  int n_pass   = 0;

  vt52_cmd_engine dut (
    .clk                (clk),
    .reset              (reset),
    .data               (data),
    .valid              (valid),
    .ready              (ready),
    .new_first_char     (new_first_char),
    .new_first_char_wen (new_first_char_wen),
    .new_char           (new_char),
    .new_char_address   (new_char_address),
    .new_char_wen       (new_char_wen),
    .new_cursor_x       (new_cursor_x),
    .new_cursor_y       (new_cursor_y),
    .new_cursor_wen     (new_cursor_wen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        cw;
    logic [10:0] ad;
    logic [7:0]  ch;
    logic        cuw;
    logic [6:0]  x;
    logic [4:0]  y;
    logic        fw;
  } vec_t;

  vec_t vt [45];

  function automatic vec_t mk(input logic [7:0] d, input logic cw, input int ad, input logic [7:0] ch,
                              input logic cuw, input int x, input int y, input logic fw);
    vec_t v;
    v.d = d; v.cw = cw; v.ad = 11'(ad); v.ch = ch;
    v.cuw = cuw; v.x = 7'(x); v.y = 5'(y); v.fw = fw;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at a sample point; waits (bounded) for ready, then presents the byte for one edge.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    while (!ready && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ready) check("send_wait_ready", 64'(ready), 64'd1);
    data  = b;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Follows a clear sweep until ready returns; every write must be a blank at the
  // next sequential ring address, with ready low and no scroll strobe alongside.
  task automatic check_sweep(input string name, input int start, input int count);
    int n, bad, cyc, exp_a;
    n = 0; bad = 0; cyc = 0; exp_a = start;
    while (!ready && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (new_char_wen) begin
        if (int'(new_char_address) != exp_a || new_char != 8'h20 || ready || new_first_char_wen) bad++;
        n++;
        exp_a = (exp_a == 1999) ? 0 : exp_a + 1;
      end
    end
    if (!ready) bad++;
    check({name, "_count"}, 64'(n), 64'(count));
    check({name, "_cells"}, 64'(bad), 64'd0);
  endtask

  task automatic check_reset_state(input string name);
    check(name, {ready, new_char_wen, new_first_char_wen, new_cursor_wen, new_char,
                 new_char_address, new_cursor_x, new_cursor_y, new_first_char},
          {4'b0000, 8'h20, 11'd0, 7'd0, 5'd0, 11'd0});
  endtask

  initial begin
    int extra;
    //           data   cw  addr  char  cuw  x   y  fw
    vt[0]  = mk(8'h41, 1,  0,   8'h41, 1,  1,  0, 0);
    vt[1]  = mk(8'h42, 1,  1,   8'h42, 1,  2,  0, 0);
    vt[2]  = mk(8'h0D, 0,  0,   8'h00, 1,  0,  0, 0);
    vt[3]  = mk(8'h0A, 0,  0,   8'h00, 1,  0,  1, 0);
    vt[4]  = mk(8'h09, 0,  0,   8'h00, 1,  8,  1, 0);
    vt[5]  = mk(8'h78, 1,  88,  8'h78, 1,  9,  1, 0);
    vt[6]  = mk(8'h08, 0,  0,   8'h00, 1,  8,  1, 0);
    vt[7]  = mk(8'h09, 0,  0,   8'h00, 1,  16, 1, 0);
    vt[8]  = mk(8'h7F, 0,  0,   8'h00, 0,  16, 1, 0);
    vt[9]  = mk(8'h01, 0,  0,   8'h00, 0,  16, 1, 0);
    vt[10] = mk(8'hC5, 1,  96,  8'hC5, 1,  17, 1, 0);
    vt[11] = mk(8'h1B, 0,  0,   8'h00, 0,  17, 1, 0);
    vt[12] = mk(8'h41, 0,  0,   8'h00, 1,  17, 0, 0);
    vt[13] = mk(8'h1B, 0,  0,   8'h00, 0,  17, 0, 0);
    vt[14] = mk(8'h41, 0,  0,   8'h00, 1,  17, 0, 0);
    vt[15] = mk(8'h1B, 0,  0,   8'h00, 0,  17, 0, 0);
    vt[16] = mk(8'h44, 0,  0,   8'h00, 1,  16, 0, 0);
    vt[17] = mk(8'h1B, 0,  0,   8'h00, 0,  16, 0, 0);
    vt[18] = mk(8'h43, 0,  0,   8'h00, 1,  17, 0, 0);
    vt[19] = mk(8'h1B, 0,  0,   8'h00, 0,  17, 0, 0);
    vt[20] = mk(8'h42, 0,  0,   8'h00, 1,  17, 1, 0);
    vt[21] = mk(8'h1B, 0,  0,   8'h00, 0,  17, 1, 0);
    vt[22] = mk(8'h48, 0,  0,   8'h00, 1,  0,  0, 0);
    vt[23] = mk(8'h1B, 0,  0,   8'h00, 0,  0,  0, 0);
    vt[24] = mk(8'h59, 0,  0,   8'h00, 0,  0,  0, 0);
    vt[25] = mk(8'h25, 0,  0,   8'h00, 0,  0,  0, 0);
    vt[26] = mk(8'h2A, 0,  0,   8'h00, 1,  10, 5, 0);
    vt[27] = mk(8'h1B, 0,  0,   8'h00, 0,  10, 5, 0);
    vt[28] = mk(8'h59, 0,  0,   8'h00, 0,  10, 5, 0);
    vt[29] = mk(8'h7F, 0,  0,   8'h00, 0,  10, 5, 0);
    vt[30] = mk(8'h7F, 0,  0,   8'h00, 1,  79, 24, 0);
    vt[31] = mk(8'h1B, 0,  0,   8'h00, 0,  79, 24, 0);
    vt[32] = mk(8'h59, 0,  0,   8'h00, 0,  79, 24, 0);
    vt[33] = mk(8'h10, 0,  0,   8'h00, 0,  79, 24, 0);
    vt[34] = mk(8'h10, 0,  0,   8'h00, 1,  0,  0, 0);
    vt[35] = mk(8'h1B, 0,  0,   8'h00, 0,  0,  0, 0);
    vt[36] = mk(8'h5A, 0,  0,   8'h00, 0,  0,  0, 0);
    vt[37] = mk(8'h08, 0,  0,   8'h00, 1,  0,  0, 0);
    vt[38] = mk(8'h1B, 0,  0,   8'h00, 0,  0,  0, 0);
    vt[39] = mk(8'h59, 0,  0,   8'h00, 0,  0,  0, 0);
    vt[40] = mk(8'h20, 0,  0,   8'h00, 0,  0,  0, 0);
    vt[41] = mk(8'h6D, 0,  0,   8'h00, 1,  77, 0, 0);
    vt[42] = mk(8'h09, 0,  0,   8'h00, 1,  79, 0, 0);
    vt[43] = mk(8'h71, 1,  79,  8'h71, 1,  0,  1, 0);
    vt[44] = mk(8'h72, 1,  80,  8'h72, 1,  1,  1, 0);

    // Power-on: reset values, then a full-screen blanking sweep.
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por_reset_values");
    reset = 1'b0;
    check_sweep("por_sweep", 0, 2000);
    check("por_idle", {ready, new_cursor_x, new_cursor_y}, {1'b1, 7'd0, 5'd0});

    for (int i = 0; i < 45; i++) begin
      send_byte(vt[i].d);
      check($sformatf("vec%0d", i),
            {new_char_wen, (vt[i].cw ? new_char_address : 11'd0), (vt[i].cw ? new_char : 8'd0),
             new_cursor_wen, new_cursor_x, new_cursor_y, new_first_char_wen},
            {vt[i].cw, vt[i].ad, vt[i].ch, vt[i].cuw, vt[i].x, vt[i].y, vt[i].fw});
    end

    // Line feed on the bottom row scrolls and blanks the new bottom row.
    send_byte(8'h1B); send_byte(8'h59); send_byte(8'h38); send_byte(8'h20);
    check("goto_bottom", {new_cursor_x, new_cursor_y}, {7'd0, 5'd24});
    send_byte(8'h0A);
    check("scroll_strobe", {new_first_char_wen, new_first_char, new_char_wen, new_cursor_x, new_cursor_y},
          {1'b1, 11'd80, 1'b0, 7'd0, 5'd24});
    check_sweep("scroll_sweep", 0, 80);
    check("scroll_after", {new_first_char, new_cursor_x, new_cursor_y}, {11'd80, 7'd0, 5'd24});

    // Printing on the bottom row wraps its address around the ring.
    send_byte(8'h57);
    check("ring_wrap_print", {new_char_wen, new_char_address, new_char, new_cursor_x, new_cursor_y},
          {1'b1, 11'd0, 8'h57, 7'd1, 5'd24});

    // ESC K from (70,3) with first_char 80.
    send_byte(8'h1B); send_byte(8'h59); send_byte(8'h23); send_byte(8'h66);
    send_byte(8'h1B); send_byte(8'h4B);
    check("esc_k_trigger", {new_char_wen, new_first_char_wen}, 2'b00);
    check_sweep("esc_k_sweep", 390, 10);
    check("esc_k_cursor", {new_cursor_x, new_cursor_y}, {7'd70, 5'd3});

    // ESC J from (0,24) with first_char 80.
    send_byte(8'h1B); send_byte(8'h59); send_byte(8'h38); send_byte(8'h20);
    send_byte(8'h1B); send_byte(8'h4A);
    check_sweep("esc_j_sweep", 0, 80);

    // ESC E with a byte held valid throughout the sweep.
    send_byte(8'h1B); send_byte(8'h45);
    check("esc_e_strobe", {new_first_char_wen, new_first_char, new_cursor_wen, new_char_wen,
                           new_cursor_x, new_cursor_y}, {1'b1, 11'd0, 1'b1, 1'b0, 7'd0, 5'd0});
    data  = 8'h5A;
    valid = 1'b1;
    check_sweep("esc_e_sweep", 0, 2000);
    @(posedge clk); #1;
    valid = 1'b0;
    check("held_byte_write", {new_char_wen, new_char_address, new_char, new_cursor_x, new_cursor_y},
          {1'b1, 11'd0, 8'h5A, 7'd1, 5'd0});
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (new_char_wen) extra++;
    end
    check("held_byte_once", 64'(extra), 64'd0);

    // Reset in the middle of a scroll sweep restarts the full power-on clear.
    send_byte(8'h1B); send_byte(8'h59); send_byte(8'h38); send_byte(8'h20);
    send_byte(8'h0A);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check_reset_state("mid_reset_values");
    reset = 1'b0;
    check_sweep("mid_reset_sweep", 0, 2000);
    check("mid_reset_idle", {ready, new_cursor_x, new_cursor_y, new_first_char},
          {1'b1, 7'd0, 5'd0, 11'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
